bist_resp_ctrl: RTL and testbench

BIST_RESP_CTRL -- requirements
Module: bist_resp_ctrl

---
 rtl/bist_resp_ctrl.sv | 98 +++++++++
 tb/tb_bist_resp_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bist_resp_ctrl.sv
// bist_resp_ctrl: scan BIST sequencer with 7-input MISR response compaction and golden compare.
// Define BIST_SIG_OBS_EN to expose the MISR contents on the signature port.
module bist_resp_ctrl #(
    parameter int         CHAIN_LEN  = 33,
    parameter int         PATTERNS   = 100,
    parameter logic [6:0] GOLDEN_SIG = 7'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] scan_outs,
    output logic       scan_en,
    output logic       bist_en,
    output logic       tpg_reset,
    output logic       busy,
    output logic       done,
    output logic       pass
`ifdef BIST_SIG_OBS_EN
    ,
    output logic [6:0] signature
`endif
);
    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam logic [SW-1:0] SH_LAST = SW'(CHAIN_LEN - 1);
    localparam logic [15:0] PAT_N = 16'(PATTERNS);

    typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, COMPARE, DONE} state_t;

    state_t         state;
    logic [SW-1:0]  sh_cnt;
    logic [15:0]    pat_cnt;
    logic [6:0]     misr;

`ifdef BIST_SIG_OBS_EN
    assign signature = misr;
`endif

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            misr      <= '0;
            sh_cnt    <= '0;
            pat_cnt   <= '0;
            scan_en   <= 1'b0;
            bist_en   <= 1'b0;
            tpg_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= INIT;
                    misr      <= '0;
                    sh_cnt    <= '0;
                    pat_cnt   <= '0;
                    bist_en   <= 1'b1;
                    tpg_reset <= 1'b1;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                end
                INIT: begin
                    state     <= SHIFT;
                    scan_en   <= 1'b1;
                    tpg_reset <= 1'b0;
                end
                SHIFT: begin
                    // The first phase only loads the chains, so its unload is not compacted.
                    if (pat_cnt != '0)
                        misr <= scan_outs ^ {misr[5:0], misr[6]};
                    if (sh_cnt == SH_LAST) begin
                        sh_cnt  <= '0;
                        scan_en <= 1'b0;
                        bist_en <= 1'b0;
                        state   <= (pat_cnt < PAT_N) ? CAPTURE : COMPARE;
                    end else begin
                        sh_cnt <= sh_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    pat_cnt <= pat_cnt + 1'b1;
                    scan_en <= 1'b1;
                    bist_en <= 1'b1;
                    state   <= SHIFT;
                end
                COMPARE: begin
                    pass  <= (misr == GOLDEN_SIG);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bist_resp_ctrl.sv
// tb_bist_resp_ctrl: directed and random runs of bist_resp_ctrl against a schedule/MISR reference model.
module tb_bist_resp_ctrl;
    localparam int         C = 4;
    localparam int         P = 2;
    localparam logic [6:0] G = 7'h00;
    localparam int         RUN_EDGES = (P + 1) * (C + 1) + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] scan_outs = '0;
    logic       scan_en, bist_en, tpg_reset, busy, done, pass;
    logic [6:0] sig_obs;
    int         errors = 0;
    int         checks = 0;

`ifdef BIST_SIG_OBS_EN
    logic [6:0] signature;
    assign sig_obs = signature;
`else
    assign sig_obs = dut.misr;
`endif

    bist_resp_ctrl #(.CHAIN_LEN(C), .PATTERNS(P), .GOLDEN_SIG(G)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .scan_outs(scan_outs),
        .scan_en(scan_en), .bist_en(bist_en), .tpg_reset(tpg_reset),
        .busy(busy), .done(done), .pass(pass)
`ifdef BIST_SIG_OBS_EN
        , .signature(signature)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected activity after the k-th edge following the start edge: 0 INIT, 1 SHIFT, 2 CAPTURE, 3 COMPARE, 4 DONE.
    function automatic int kind(input int k);
        int t;
        if (k == 0) return 0;
        if (k >= RUN_EDGES) return 4;
        t = k - 1;
        if (t % (C + 1) < C) return 1;
        return (t / (C + 1) < P) ? 2 : 3;
    endfunction

    function automatic logic [6:0] ctrl_exp(input int k);
        int kd;
        kd = kind(k);
        return {2'b00, kd == 1, kd <= 1, kd == 0, kd < 4, kd == 4};
    endfunction

    function automatic logic [6:0] rotl(input logic [6:0] x);
        return {x[5:0], x[6]};
    endfunction

    // mode 0: all zero, 1: 7F in load phase only, 2: 01 in final shift cycle only, 3: random
    task automatic run(input int mode);
        logic [6:0] exp_sig;
        logic [6:0] so;
        int ph, off;
        exp_sig = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ctrl k=0", {2'b00, scan_en, bist_en, tpg_reset, busy, done}, ctrl_exp(0));
        for (int k = 1; k <= RUN_EDGES; k++) begin
            so = '0;
            if (kind(k - 1) == 1) begin
                ph  = (k - 2) / (C + 1);
                off = (k - 2) % (C + 1);
                so = (mode == 1 && ph == 0) ? 7'h7F :
                     (mode == 2 && ph == P && off == C - 1) ? 7'h01 :
                     (mode == 3) ? 7'($urandom) : 7'h00;
                if (ph >= 1) exp_sig = rotl(exp_sig) ^ so;
            end else if (mode == 3) begin
                so = 7'($urandom);
            end
            scan_outs = so;
            start = 1'($urandom);
            step();
            chk($sformatf("ctrl m=%0d k=%0d", mode, k),
                {2'b00, scan_en, bist_en, tpg_reset, busy, done}, ctrl_exp(k));
        end
        start = 1'b0;
        chk($sformatf("pass m=%0d", mode), {6'b0, pass}, {6'b0, exp_sig == G});
        chk($sformatf("sig m=%0d", mode), sig_obs, exp_sig);
        for (int i = 0; i < 2; i++) begin
            scan_outs = 7'($urandom);
            step();
            chk($sformatf("hold m=%0d", mode), {done, sig_obs[5:0]}, {1'b1, exp_sig[5:0]});
        end
    endtask

    initial begin
        #2;
        chk("reset outs", {2'b00, scan_en, bist_en, tpg_reset, busy, done}, 7'h00);
        chk("reset sig", sig_obs, 7'h00);
        #10 reset_n = 1'b1;
        step();
        chk("idle outs", {1'b0, scan_en, bist_en, tpg_reset, busy, done, pass}, 7'h00);
        run(0);
        run(1);
        run(2);
        for (int r = 0; r < 4; r++) run(3);
        // abort in the second shift phase
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            scan_outs = 7'($urandom) | 7'h01;
            step();
        end
        chk("mid busy", {6'b0, busy}, 7'h01);
        #2 reset_n = 1'b0;
        #1;
        chk("abort outs", {1'b0, scan_en, bist_en, tpg_reset, busy, done, pass}, 7'h00);
        chk("abort sig", sig_obs, 7'h00);
        #2 reset_n = 1'b1;
        step();
        chk("post abort idle", {1'b0, scan_en, bist_en, tpg_reset, busy, done, pass}, 7'h00);
        run(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
